// File: rtl/mem_fill.sv
// mem_fill: fills a region of a single-port RAM with one word per clock.
// A request is taken on the rdy/en handshake. It is then written as N
// consecutive words, starting at base and wrapping at the top of the
// address space. A normal finish ends with a one-cycle done pulse. An abort
// during the fill returns the block to idle without a done pulse.
module mem_fill #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rdy,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_IDENT = 2'd0;
  localparam logic [1:0] M_DESC  = 2'd1;
  localparam logic [1:0] M_CONST = 2'd2;
  localparam logic [1:0] M_XORK  = 2'd3;

  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] fv_q;
  logic [ADDR_W:0]   n_q;     // word count; one extra bit so len=0 means 2**ADDR_W
  logic [ADDR_W:0]   i_q;     // index of the next word to write
  logic [ADDR_W:0]   i_last;
  logic [ADDR_W:0]   desc_k;

  // Index counts are ADDR_W+1 bits wide. Zero-extend or truncate them to the data width.
  function automatic logic [DATA_W-1:0] fit(input logic [ADDR_W:0] v);
    logic [DATA_W+ADDR_W:0] wide;
    wide = {{DATA_W{1'b0}}, v};
    return wide[DATA_W-1:0];
  endfunction

  // Data word for index k under the latched pattern mode.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [ADDR_W:0]   k,
                                                input logic [ADDR_W:0]   dk,
                                                input logic [DATA_W-1:0] fv);
    logic [DATA_W-1:0] r;
    case (m)
      M_DESC:  r = fit(dk);
      M_CONST: r = fv;
      M_XORK:  r = fit(k) ^ fv;
      default: r = fit(k);
    endcase
    return r;
  endfunction

  assign i_last = n_q - CNT_ONE;
  assign desc_k = i_last - i_q;

  // Control FSM plus the registered RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      i_q      <= '0;
      rdy      <= 1'b0;
      done     <= 1'b0;
      ram_wren <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          ram_wren <= 1'b0;
          if (en && rdy) begin
            mode_q <= mode;
            base_q <= base;
            fv_q   <= fill_val;
            n_q    <= (len == '0) ? CNT_FULL : {1'b0, len};
            i_q    <= '0;
            rdy    <= 1'b0;
            state  <= S_FILL;
          end else begin
            rdy <= 1'b1;
          end
        end
        S_FILL: begin
          if (abort) begin
            ram_wren <= 1'b0;
            rdy      <= 1'b1;
            state    <= S_IDLE;
          end else begin
            ram_wren <= 1'b1;
            ram_addr <= base_q + i_q[ADDR_W-1:0];
            ram_din  <= pattern(mode_q, i_q, desc_k, fv_q);
            if (i_q == i_last) begin
              state <= S_DONE;
            end else begin
              i_q <= i_q + CNT_ONE;
            end
          end
        end
        S_DONE: begin
          ram_wren <= 1'b0;
          done     <= 1'b1;
          rdy      <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          ram_wren <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill.sv
// tb_mem_fill: table-driven and randomized bench for mem_fill. It runs an
// 8-bit-address instance and a 4-bit-address instance.
module tb_mem_fill;

  logic       clk;
  logic       rst;
  logic       en8, en4, abort, sel;
  logic [1:0] mode;
  logic [7:0] base, len, fill_val;

  logic       rdy8, done8, wren8;
  logic [7:0] addr8, din8;
  logic       rdy4, done4, wren4;
  logic [3:0] addr4;
  logic [7:0] din4;

  logic       cur_rdy, cur_done, cur_wren;
  logic [7:0] cur_addr, cur_din;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit aw4;
    int mode;
    int base;
    int len;
    int fv;
    int abort_after;
    bit abort_with_en;
    bit poke_en;
    int exp_count;
    bit exp_done;
    int first_addr;
    int first_din;
    int last_addr;
    int last_din;
  } vec_t;

  vec_t vecs[10];

  mem_fill #(.ADDR_W(8), .DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .rdy(rdy8), .en(en8), .mode(mode), .base(base),
    .len(len), .fill_val(fill_val), .abort(abort), .done(done8),
    .ram_addr(addr8), .ram_din(din8), .ram_wren(wren8)
  );

  mem_fill #(.ADDR_W(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .rdy(rdy4), .en(en4), .mode(mode), .base(base[3:0]),
    .len(len[3:0]), .fill_val(fill_val), .abort(abort), .done(done4),
    .ram_addr(addr4), .ram_din(din4), .ram_wren(wren4)
  );

  assign cur_rdy  = sel ? rdy4  : rdy8;
  assign cur_done = sel ? done4 : done8;
  assign cur_wren = sel ? wren4 : wren8;
  assign cur_addr = sel ? {4'b0, addr4} : addr8;
  assign cur_din  = sel ? din4  : din8;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the word count, and write k's address and data, for one request.
  function automatic int words(input int aw, input int l);
    int m;
    m = l % (1 << aw);
    return (m == 0) ? (1 << aw) : m;
  endfunction

  function automatic int model_addr(input int aw, input int b, input int k);
    return (b + k) % (1 << aw);
  endfunction

  function automatic int model_din(input int md, input int n, input int k, input int fv);
    int r;
    case (md)
      0: r = k;
      1: r = n - 1 - k;
      2: r = fv;
      default: r = k ^ fv;
    endcase
    return r & 'hFF;
  endfunction

  task automatic run_fill(input vec_t v, input string tag);
    int aw, n, waitc;
    int got_a[$];
    int got_d[$];
    bit done_seen, abort_sent, finished, busy_bad, poked, done_wren;
    logic rdy_end;
    int quiet;
    aw = v.aw4 ? 4 : 8;
    n  = words(aw, v.len);
    sel = v.aw4;
    done_seen = 0; abort_sent = 0; finished = 0; busy_bad = 0; poked = 0;
    done_wren = 0; rdy_end = 1'b0;
    waitc = 0;
    while (!cur_rdy && waitc < 50) begin
      step();
      waitc++;
    end
    check({tag, "_rdy_before"}, cur_rdy, 1);
    mode = v.mode[1:0]; base = v.base[7:0]; len = v.len[7:0]; fill_val = v.fv[7:0];
    if (v.aw4) en4 = 1'b1; else en8 = 1'b1;
    abort = v.abort_with_en;
    step();
    en4 = 1'b0; en8 = 1'b0; abort = 1'b0;
    mode = 2'($urandom); base = 8'($urandom); len = 8'($urandom); fill_val = 8'($urandom);
    check({tag, "_rdy_busy"}, cur_rdy, 0);
    for (int c = 0; c < n + 20 && !finished; c++) begin
      if (v.poke_en && !poked && got_a.size() == 2) begin
        if (v.aw4) en4 = 1'b1; else en8 = 1'b1;
        poked = 1;
      end
      step();
      en4 = 1'b0; en8 = 1'b0;
      if (abort_sent) begin
        abort = 1'b0;
        check({tag, "_abort_wren"}, cur_wren, 0);
        check({tag, "_abort_done"}, cur_done, 0);
        rdy_end = cur_rdy;
        finished = 1;
      end else begin
        if (cur_wren) begin
          got_a.push_back(int'(cur_addr));
          got_d.push_back(int'(cur_din));
          if (cur_rdy) busy_bad = 1;
        end
        if (cur_done) begin
          done_seen = 1;
          done_wren = cur_wren;
          rdy_end = cur_rdy;
          finished = 1;
        end else if (v.abort_after > 0 && got_a.size() == v.abort_after) begin
          abort = 1'b1;
          abort_sent = 1;
        end
      end
    end
    abort = 1'b0;
    check({tag, "_finished"}, finished, 1);
    check({tag, "_count"}, got_a.size(), v.exp_count);
    check({tag, "_done"}, done_seen, v.exp_done);
    check({tag, "_rdy_end"}, rdy_end, 1);
    check({tag, "_rdy_low_in_fill"}, busy_bad, 0);
    if (done_seen) check({tag, "_wren_at_done"}, done_wren, 0);
    for (int k = 0; k < got_a.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), got_a[k], model_addr(aw, v.base, k));
      check($sformatf("%s_din%0d", tag, k), got_d[k], model_din(v.mode, n, k, v.fv));
    end
    check({tag, "_first_addr"}, (got_a.size() > 0) ? got_a[0] : -1, v.first_addr);
    check({tag, "_first_din"}, (got_d.size() > 0) ? got_d[0] : -1, v.first_din);
    check({tag, "_last_addr"}, (got_a.size() > 0) ? got_a[got_a.size()-1] : -1, v.last_addr);
    check({tag, "_last_din"}, (got_d.size() > 0) ? got_d[got_d.size()-1] : -1, v.last_din);
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (cur_wren || cur_done) quiet++;
    end
    check({tag, "_quiet_after"}, quiet, 0);
  endtask

  initial begin
    int wcnt, dones, last_done_c, n, aa;
    bit after_done;
    int bq[$];
    vec_t rv;

    //       aw4 mode base   len    fv    ab wen pk cnt dn fa     fd     la     ld
    vecs[0] = '{0, 0, 'h00,  0,     'h00, 0, 0, 0, 256, 1, 'h00, 'h00, 'hFF, 'hFF};
    vecs[1] = '{0, 2, 'hF0,  'h20,  'hA5, 0, 0, 0, 32,  1, 'hF0, 'hA5, 'h0F, 'hA5};
    vecs[2] = '{0, 1, 'h10,  4,     'h00, 0, 0, 0, 4,   1, 'h10, 'h03, 'h13, 'h00};
    vecs[3] = '{0, 3, 'h10,  4,     'h0F, 0, 0, 0, 4,   1, 'h10, 'h0F, 'h13, 'h0C};
    vecs[4] = '{0, 0, 'h00,  8,     'h00, 3, 0, 0, 3,   0, 'h00, 'h00, 'h02, 'h02};
    vecs[5] = '{0, 1, 'hFE,  3,     'h00, 0, 0, 0, 3,   1, 'hFE, 'h02, 'h00, 'h00};
    vecs[6] = '{0, 3, 'h80,  0,     'h55, 0, 0, 0, 256, 1, 'h80, 'h55, 'h7F, 'hAA};
    vecs[7] = '{0, 0, 'h20,  5,     'h00, 0, 1, 0, 5,   1, 'h20, 'h00, 'h24, 'h04};
    vecs[8] = '{1, 0, 'h00,  0,     'h00, 0, 0, 1, 16,  1, 'h00, 'h00, 'h0F, 'h0F};
    vecs[9] = '{1, 1, 'h0C,  6,     'h33, 0, 0, 0, 6,   1, 'h0C, 'h05, 'h01, 'h00};

    rst = 1'b1; en8 = 1'b0; en4 = 1'b0; abort = 1'b0; sel = 1'b0;
    mode = '0; base = '0; len = '0; fill_val = '0;

    // Outputs are held at zero throughout reset; rdy rises on the first edge after release.
    repeat (3) step();
    check("rst_rdy8", rdy8, 0);
    check("rst_done8", done8, 0);
    check("rst_wren8", wren8, 0);
    check("rst_addr8", addr8, 0);
    check("rst_din8", din8, 0);
    check("rst_rdy4", rdy4, 0);
    check("rst_wren4", wren4, 0);
    rst = 1'b0;
    check("rdy_before_edge", rdy8, 0);
    step();
    check("rdy_after_rst8", rdy8, 1);
    check("rdy_after_rst4", rdy4, 1);

    for (int t = 0; t < 10; t++) run_fill(vecs[t], $sformatf("vec%0d", t));

    // A reset in the middle of a fill stops the writes on the next edge.
    sel = 1'b0; mode = 2'd0; base = 8'h00; len = 8'd20; en8 = 1'b1;
    step();
    en8 = 1'b0;
    wcnt = 0;
    for (int c = 0; c < 30 && wcnt < 5; c++) begin
      step();
      if (wren8) wcnt++;
    end
    check("midrst_writes_seen", wcnt, 5);
    rst = 1'b1;
    step();
    check("midrst_wren", wren8, 0);
    check("midrst_done", done8, 0);
    check("midrst_rdy", rdy8, 0);
    rst = 1'b0;
    check("midrst_rdy_low", rdy8, 0);
    step();
    check("midrst_rdy_rise", rdy8, 1);
    check("midrst_wren_after", wren8, 0);

    // Holding en high restarts a fill in every done cycle.
    sel = 1'b0; mode = 2'd0; base = 8'h40; len = 8'd4; fill_val = 8'h00; en8 = 1'b1;
    dones = 0; last_done_c = -1; after_done = 0;
    for (int c = 0; c < 60 && dones < 3; c++) begin
      step();
      if (wren8) begin
        bq.push_back(int'(addr8));
        if (after_done) begin
          check("b2b_gap", c - last_done_c, 2);
          after_done = 0;
        end
      end
      if (done8) begin
        dones++;
        last_done_c = c;
        after_done = 1;
        check("b2b_rdy_at_done", rdy8, 1);
      end
    end
    en8 = 1'b0;
    check("b2b_dones", dones, 3);
    check("b2b_writes", bq.size(), 12);
    for (int k = 0; k < bq.size(); k++)
      check($sformatf("b2b_addr%0d", k), bq[k], 'h40 + (k % 4));
    repeat (3) step();
    check("b2b_idle_rdy", rdy8, 1);
    check("b2b_idle_wren", wren8, 0);

    // Random requests, each checked against the model.
    for (int t = 0; t < 24; t++) begin
      rv.aw4 = ($urandom_range(0, 3) == 0);
      rv.mode = $urandom_range(0, 3);
      rv.base = $urandom_range(0, 255);
      rv.len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
      rv.fv = $urandom_range(0, 255);
      n = words(rv.aw4 ? 4 : 8, rv.len);
      aa = ($urandom_range(0, 3) == 0 && n > 1) ? $urandom_range(1, n - 1) : 0;
      rv.abort_after = aa;
      rv.abort_with_en = $urandom_range(0, 1);
      rv.poke_en = $urandom_range(0, 1) && (aa == 0);
      rv.exp_count = (aa > 0) ? aa : n;
      rv.exp_done = (aa == 0);
      rv.first_addr = model_addr(rv.aw4 ? 4 : 8, rv.base, 0);
      rv.first_din = model_din(rv.mode, n, 0, rv.fv);
      rv.last_addr = model_addr(rv.aw4 ? 4 : 8, rv.base, rv.exp_count - 1);
      rv.last_din = model_din(rv.mode, n, rv.exp_count - 1, rv.fv);
      run_fill(rv, $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
